hazard_swap_sequencer: RTL
==========================

// Module: hazard_swap_sequencer
// PURPOSE
//  ID-stage pipeline sequencer beside Control_unit. Detects RAW hazards against EXE/MEM and
//  raises freeze/bubble, sequences the two-cycle SWP instruction (opcode 6'b111111) through a
//  real FSM, and applies the taken-branch flush. Owns freeze, swp_sel and the SWP exec_cmd override.
// PARAMETERS
//  REG_AW      5          register index width; index 0 is never a hazard source
//  OPC_W       6          opcode width
//  SWP_OPCODE  6'b111111  opcode of the two-phase swap
//  CNT_W       16         stall performance counter width
// PORTS
//  clk           in   1       clock, rising edge
//  rst           in   1       asynchronous, active-high reset
//  id_valid      in   1       ID holds a real instruction
//  id_opcode     in   OPC_W   opcode in ID
//  id_src1       in   REG_AW  first source register
//  id_src2       in   REG_AW  second source register; ignored when id_single_src=1
//  id_single_src in   1       instruction reads src1 only
//  exe_dest      in   REG_AW  EXE destination register
//  exe_wb_en     in   1       EXE writes back
//  exe_mem_r_en  in   1       EXE is a load
//  mem_dest      in   REG_AW  MEM destination register
//  mem_wb_en     in   1       MEM writes back
//  fwd_en        in   1       forwarding unit active
//  branch_taken  in   1       branch resolved taken in EXE
//  freeze        out  1       hold PC and IF/ID
//  bubble        out  1       inject NOP into ID/EX
//  flush         out  1       kill IF/ID contents
//  swp_sel       out  2       00 none, 01 SWP phase 1, 10 SWP phase 2
//  cmd_ovr       out  1       exec_cmd_ovr is valid and replaces Control_unit exec_cmd
//  exec_cmd_ovr  out  4       4'b1100 phase 1, 4'b1101 phase 2, otherwise 0
//  stall_count   out  CNT_W   count of cycles with bubble=1; wraps
// BEHAVIOUR
//  - Reset: state=IDLE and stall_count=0. While rst=1, every output is 0.
//  - Outputs are combinational from state and inputs. No latency is added to the pipeline.
//  - hit(d,en) = en && d!=0 && (d==id_src1 || (!id_single_src && d==id_src2)).
//  - hazard = id_valid && (fwd_en ? hit(exe_dest,exe_wb_en)&&exe_mem_r_en
//             : hit(exe_dest,exe_wb_en) || hit(mem_dest,mem_wb_en)).
//  - Priority: branch_taken > hazard > SWP.
//  - FSM states are IDLE and SWP2.
//  - IDLE, branch_taken=1: flush=1, bubble=1, freeze=0, swp_sel=0. Stay in IDLE.
//  - IDLE, hazard=1: freeze=1, bubble=1, swp_sel=0. Stay in IDLE.
//  - IDLE, id_valid && id_opcode==SWP_OPCODE, no hazard: freeze=1, swp_sel=01, cmd_ovr=1,
//    exec_cmd=1100. Next state SWP2.
//  - SWP2: freeze=0, swp_sel=10, cmd_ovr=1, exec_cmd=1101. Next state IDLE.
//    Hazards are not re-checked in SWP2; the operands are already latched.
//  - SWP2 with branch_taken=1: abort with flush=1, bubble=1, swp_sel=0, cmd_ovr=0. Next state IDLE.
//  - Back-to-back SWP: after SWP2 the next SWP enters phase 1 normally. The gap is 0 cycles.
//  - stall_count increments on each cycle with bubble=1 and wraps from all-ones to 0.
//  - Reset mid-SWP returns the FSM to IDLE immediately. No phase-2 output follows.
// STRUCTURE
//  - Shared package pipe_pkg: SWP_OPCODE, SWP_SEL_{NONE,P1,P2}, EXEC_SWP_{P1,P2},
//    and the seq_state_t enum {IDLE,SWP2}.
//  - One sub-module, hazard_detect: purely combinational hit/hazard logic, reusable by the
//    forwarding unit.
//  - FSM and counter stay in this module.
// TESTING
//  1 ADD r3 in EXE (wb=1), ID src1=r3, fwd_en=0
//    -> freeze=1, bubble=1, stall_count 0->1.
//  2 Same as 1 with fwd_en=1, exe_mem_r_en=0
//    -> freeze=0, bubble=0.
//  3 Same as 2 with exe_mem_r_en=1 (load-use)
//    -> exactly 1 stall cycle.
//  4 SWP in ID, no hazard
//    -> cycle 0: swp_sel=01, cmd 1100, freeze=1
//    -> cycle 1: swp_sel=10, cmd 1101, freeze=0
//    -> cycle 2: IDLE.
//  5 SWP phase 1, then branch_taken=1 in cycle 1
//    -> flush=1, swp_sel=00, cmd_ovr=0, next state IDLE.
//  6 id_src1=0 with exe_dest=0, wb=1 -> no stall.
//    Then rst pulse mid-SWP -> all outputs 0, stall_count=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline constants for the ID-stage sequencer: SWP opcode,
// swap-phase select codes, exec_cmd overrides and the sequencer state type.
package pipe_pkg;

    localparam logic [5:0] SWP_OPCODE   = 6'b111111;

    localparam logic [1:0] SWP_SEL_NONE = 2'b00;
    localparam logic [1:0] SWP_SEL_P1   = 2'b01;
    localparam logic [1:0] SWP_SEL_P2   = 2'b10;

    localparam logic [3:0] EXEC_SWP_P1  = 4'b1100;
    localparam logic [3:0] EXEC_SWP_P2  = 4'b1101;

    typedef enum logic {
        IDLE = 1'b0,
        SWP2 = 1'b1
    } seq_state_t;

endpackage

// File: rtl/hazard_detect.sv
// Purely combinational RAW hazard detection of the ID-stage sources against
// the EXE and MEM destinations. Kept separate so the forwarding unit can reuse it.
module hazard_detect #(
    parameter int REG_AW = 5
) (
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_src1,
    input  logic [REG_AW-1:0] id_src2,
    input  logic              id_single_src,
    input  logic [REG_AW-1:0] exe_dest,
    input  logic              exe_wb_en,
    input  logic              exe_mem_r_en,
    input  logic [REG_AW-1:0] mem_dest,
    input  logic              mem_wb_en,
    input  logic              fwd_en,
    output logic              hazard
);

    // Register 0 is hard-wired, so it never creates a dependency.
    function automatic logic hit(input logic [REG_AW-1:0] d, input logic en);
        return en && (d != '0) &&
               ((d == id_src1) || (!id_single_src && (d == id_src2)));
    endfunction

    logic exe_hit;
    logic mem_hit;

    // With forwarding only a load in EXE still has to stall; otherwise any
    // pending write in EXE or MEM does.
    always_comb begin
        exe_hit = hit(exe_dest, exe_wb_en);
        mem_hit = hit(mem_dest, mem_wb_en);
        if (fwd_en) begin
            hazard = id_valid && exe_hit && exe_mem_r_en;
        end else begin
            hazard = id_valid && (exe_hit || mem_hit);
        end
    end

endmodule

// File: rtl/hazard_swap_sequencer.sv
// ID-stage sequencer beside the control unit: stalls on RAW hazards, sequences
// the two-phase SWP instruction, applies taken-branch flush, counts stall cycles.
module hazard_swap_sequencer
    import pipe_pkg::*;
#(
    parameter int               REG_AW     = 5,
    parameter int               OPC_W      = 6,
    parameter logic [OPC_W-1:0] SWP_OPCODE = pipe_pkg::SWP_OPCODE,
    parameter int               CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [OPC_W-1:0]  id_opcode,
    input  logic [REG_AW-1:0] id_src1,
    input  logic [REG_AW-1:0] id_src2,
    input  logic              id_single_src,
    input  logic [REG_AW-1:0] exe_dest,
    input  logic              exe_wb_en,
    input  logic              exe_mem_r_en,
    input  logic [REG_AW-1:0] mem_dest,
    input  logic              mem_wb_en,
    input  logic              fwd_en,
    input  logic              branch_taken,
    output logic              freeze,
    output logic              bubble,
    output logic              flush,
    output logic [1:0]        swp_sel,
    output logic              cmd_ovr,
    output logic [3:0]        exec_cmd_ovr,
    output logic [CNT_W-1:0]  stall_count
);

    seq_state_t       state_q, state_d;
    logic [CNT_W-1:0] stall_count_q;

    logic       hazard;
    logic       freeze_c, bubble_c, flush_c, cmd_ovr_c;
    logic [1:0] swp_sel_c;
    logic [3:0] exec_cmd_c;

    hazard_detect #(
        .REG_AW (REG_AW)
    ) u_hazard_detect (
        .id_valid      (id_valid),
        .id_src1       (id_src1),
        .id_src2       (id_src2),
        .id_single_src (id_single_src),
        .exe_dest      (exe_dest),
        .exe_wb_en     (exe_wb_en),
        .exe_mem_r_en  (exe_mem_r_en),
        .mem_dest      (mem_dest),
        .mem_wb_en     (mem_wb_en),
        .fwd_en        (fwd_en),
        .hazard        (hazard)
    );

    // Next-state and output decode; priority is branch, then hazard, then SWP.
    // Phase 2 does not re-check hazards because its operands were latched in phase 1.
    always_comb begin
        state_d    = state_q;
        freeze_c   = 1'b0;
        bubble_c   = 1'b0;
        flush_c    = 1'b0;
        cmd_ovr_c  = 1'b0;
        swp_sel_c  = SWP_SEL_NONE;
        exec_cmd_c = 4'b0000;
        if (state_q == SWP2) begin
            state_d = IDLE;
            if (branch_taken) begin
                flush_c  = 1'b1;
                bubble_c = 1'b1;
            end else begin
                swp_sel_c  = SWP_SEL_P2;
                cmd_ovr_c  = 1'b1;
                exec_cmd_c = EXEC_SWP_P2;
            end
        end else begin
            if (branch_taken) begin
                flush_c  = 1'b1;
                bubble_c = 1'b1;
            end else if (hazard) begin
                freeze_c = 1'b1;
                bubble_c = 1'b1;
            end else if (id_valid && (id_opcode == SWP_OPCODE)) begin
                freeze_c   = 1'b1;
                swp_sel_c  = SWP_SEL_P1;
                cmd_ovr_c  = 1'b1;
                exec_cmd_c = EXEC_SWP_P1;
                state_d    = SWP2;
            end
        end
    end

    // Sequencer state register; reset aborts any SWP in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Stall performance counter, one count per bubble cycle, free-running wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count_q <= '0;
        end else if (bubble_c) begin
            stall_count_q <= stall_count_q + 1'b1;
        end
    end

    // Outputs are forced low for as long as reset is held.
    always_comb begin
        freeze       = freeze_c  && !rst;
        bubble       = bubble_c  && !rst;
        flush        = flush_c   && !rst;
        cmd_ovr      = cmd_ovr_c && !rst;
        swp_sel      = rst ? SWP_SEL_NONE : swp_sel_c;
        exec_cmd_ovr = rst ? 4'b0000 : exec_cmd_c;
        stall_count  = stall_count_q;
    end

endmodule
